// File: rtl/mantissa_mult_seq.sv
// mantissa_mult_seq
// Sequential shift-and-add unsigned multiplier for the mantissa datapath.
// An external adder (alu_c, hardwired to add) is driven through alu_A_out/
// alu_B_out, and its sum/carry come back on alu_sum_in/alu_C_in each cycle.
// The full 2*WIDTH-bit product is accumulated over WIDTH CALC cycles and
// handed on with a one-cycle done strobe.
//
// Ports:
//   clk_in       - clock, rising edge
//   rst_n_in     - asynchronous active-low reset
//   start_in     - multiply request, sampled only in IDLE
//   mult_A_in    - multiplicand, latched on accepted start
//   mult_B_in    - multiplier, latched on accepted start
//   alu_A_out    - adder operand A (accumulator high half during CALC)
//   alu_B_out    - adder operand B (multiplicand or zero during CALC)
//   alu_op_out   - adder op select, always add (0)
//   alu_sum_in   - adder sum
//   alu_C_in     - adder carry out
//   product_out  - registered product, updated only on CALC->DONE
//   busy_out     - high in CALC and DONE
//   done_out     - one-cycle strobe with each new product
module mantissa_mult_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start_in,
  input  logic [WIDTH-1:0]   mult_A_in,
  input  logic [WIDTH-1:0]   mult_B_in,
  output logic [WIDTH-1:0]   alu_A_out,
  output logic [WIDTH-1:0]   alu_B_out,
  output logic               alu_op_out,
  input  logic [WIDTH-1:0]   alu_sum_in,
  input  logic               alu_C_in,
  output logic [2*WIDTH-1:0] product_out,
  output logic               busy_out,
  output logic               done_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic [CNT_W-1:0]   cnt;

  // Shift the adder result right by one: the carry becomes the new MSB of
  // the accumulator and the sum LSB drops into the top of the multiplier.
  logic [WIDTH-1:0]   next_hi;
  logic [WIDTH-1:0]   next_lo;

  always_comb begin
    next_hi = {alu_C_in, alu_sum_in[WIDTH-1:1]};
    next_lo = {alu_sum_in[0], p_lo[WIDTH-1:1]};
  end

  // Outputs are decoded from state and registers only, so there is no
  // combinational path from the adder results back to any output.
  always_comb begin
    alu_A_out  = '0;
    alu_B_out  = '0;
    alu_op_out = 1'b0;
    busy_out   = (state != IDLE);
    done_out   = (state == DONE);
    if (state == CALC) begin
      alu_A_out = p_hi;
      alu_B_out = p_lo[0] ? m : '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      m           <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      cnt         <= '0;
      product_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            m     <= mult_A_in;
            p_lo  <= mult_B_in;
            p_hi  <= '0;
            cnt   <= CNT_W'(WIDTH);
            state <= CALC;
          end
        end
        CALC: begin
          p_hi <= next_hi;
          p_lo <= next_lo;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            product_out <= {next_hi, next_lo};
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_mult_seq.sv
// Testbench for mantissa_mult_seq (WIDTH = 16) with a behavioural alu_c adder.
module tb_mantissa_mult_seq;

  localparam int unsigned W = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  mult_a;
  logic [W-1:0]  mult_b;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic          alu_op;
  logic [W-1:0]  alu_sum;
  logic          alu_c;
  logic [2*W-1:0] product;
  logic          busy;
  logic          done;

  int n_cmp;
  int n_err;
  logic [2*W-1:0] prev_prod;

  mantissa_mult_seq #(.WIDTH(W)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .start_in    (start),
    .mult_A_in   (mult_a),
    .mult_B_in   (mult_b),
    .alu_A_out   (alu_a),
    .alu_B_out   (alu_b),
    .alu_op_out  (alu_op),
    .alu_sum_in  (alu_sum),
    .alu_C_in    (alu_c),
    .product_out (product),
    .busy_out    (busy),
    .done_out    (done)
  );

  // External alu_c: add when op = 0, subtract otherwise.
  always_comb begin
    if (alu_op == 1'b0) {alu_c, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b};
    else                {alu_c, alu_sum} = {1'b0, alu_a} - {1'b0, alu_b};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " alu_A"}, 32'(alu_a), 32'h0);
    check({name, " alu_B"}, 32'(alu_b), 32'h0);
    check({name, " alu_op"}, 32'(alu_op), 32'h0);
    check({name, " busy"}, 32'(busy), 32'h0);
    check({name, " done"}, 32'(done), 32'h0);
  endtask

  // Start at the next edge (E0) and follow the operation, sampling on
  // falling edges. Sample k is taken in the cycle after edge E(k-1), so the
  // done strobe must appear at k = 17.
  task automatic run_mult(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input bit zero_b);
    int  done_at;
    bit  busy_ok, hold_ok, b_ok, op_ok;
    @(negedge clk);
    mult_a = a; mult_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mult_a = ~a; mult_b = ~b;
    done_at = 0; busy_ok = 1; hold_ok = 1; b_ok = 1; op_ok = 1;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (alu_op !== 1'b0) op_ok = 0;
      if (done === 1'b1) done_at = k;
      else begin
        if (busy !== 1'b1) busy_ok = 0;
        if (product !== prev_prod) hold_ok = 0;
        if (zero_b && alu_b !== '0) b_ok = 0;
      end
    end
    check({name, " done cycle"}, 32'(done_at), 32'd17);
    check({name, " product"}, product, exp);
    check({name, " busy in CALC"}, 32'(busy_ok), 32'd1);
    check({name, " product held"}, 32'(hold_ok), 32'd1);
    check({name, " alu_op"}, 32'(op_ok), 32'd1);
    check({name, " busy in DONE"}, 32'(busy), 32'd1);
    if (zero_b) check({name, " alu_B zero"}, 32'(b_ok), 32'd1);
    @(negedge clk);
    check_idle_outputs({name, " after"});
    check({name, " product kept"}, product, exp);
    prev_prod = exp;
  endtask

  typedef struct {
    string          name;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    bit             zero_b;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int done_cnt;
    bit busy_seen_low;

    n_cmp = 0; n_err = 0; prev_prod = '0;
    start = 1'b0; mult_a = '0; mult_b = '0;

    vecs[0] = '{"one_x_one", 16'h8000, 16'h8000, 32'h4000_0000, 1'b0};
    vecs[1] = '{"carry",     16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0};
    vecs[2] = '{"b_zero",    16'h1234, 16'h0000, 32'h0000_0000, 1'b1};
    vecs[3] = '{"a_zero",    16'h0000, 16'hABCD, 32'h0000_0000, 1'b1};
    vecs[4] = '{"mixed",     16'h1234, 16'h5678, 32'h0626_0060, 1'b0};
    vecs[5] = '{"ones_lsb",  16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0};
    vecs[6] = '{"high_bits", 16'hC000, 16'hA000, 32'h7800_0000, 1'b0};

    // Reset asserted before the first clock edge must clear everything.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("reset async");
    check("reset product", product, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check_idle_outputs("idle after reset");
    check("idle product", product, 32'h0);

    for (int i = 0; i < 7; i++)
      run_mult(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].zero_b);

    // Busy rejection: starts in CALC cycle 5 and in DONE must be ignored.
    @(negedge clk);
    mult_a = 16'h00FF; mult_b = 16'h0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 22; k++) begin
      if (k > 1) @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (k == 17) check("busy_rej product", product, 32'h0000_FFFF);
      end
      if (k == 5 || k == 17) begin
        mult_a = 16'hFFFF; mult_b = 16'hFFFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_rej done count", 32'(done_cnt), 32'd1);
    check_idle_outputs("busy_rej idle");
    check("busy_rej product kept", product, 32'h0000_FFFF);
    prev_prod = 32'h0000_FFFF;

    // Reset in CALC cycle 7 abandons the operation immediately.
    @(negedge clk);
    mult_a = 16'hC000; mult_b = 16'hA000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 7; k++) @(negedge clk);
    check("mid busy before reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid reset");
    check("mid reset product", product, 32'h0);
    done_cnt = 0;
    busy_seen_low = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (busy !== 1'b0) busy_seen_low = 0;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (busy !== 1'b0) busy_seen_low = 0;
    end
    check("mid reset no done", 32'(done_cnt), 32'd0);
    check("mid reset stays idle", 32'(busy_seen_low), 32'd1);
    prev_prod = '0;
    run_mult("post_reset", 16'h0003, 16'h0005, 32'h0000_000F, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
